// File: rtl/adc_spi_sampler.sv
// SPI master for an ADC128S022-style 8-channel 12-bit ADC. Converts the selected
// channel back-to-back while enabled and publishes each result with its channel tag.
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned OUT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           channel,
  output logic [11:0]          sample,
  output logic [2:0]           sample_ch,
  output logic [OUT_WIDTH-1:0] duty,
  output logic                 valid,
  output logic                 busy,
  output logic                 ADC_CS_N,
  output logic                 ADC_SADDR,
  output logic                 ADC_SCLK,
  input  logic                 ADC_SDAT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int unsigned    CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        div_q, div_d;
  logic                 half_q, half_d;
  logic [3:0]           bit_q, bit_d;
  logic [11:0]          shreg_q, shreg_d;
  logic [2:0]           ch_cur_q, ch_cur_d;
  logic [2:0]           ch_prev_q, ch_prev_d;
  logic                 first_q, first_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 saddr_q, saddr_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [11:0]          sample_q, sample_d;
  logic [2:0]           sample_ch_q, sample_ch_d;
  logic [OUT_WIDTH-1:0] duty_q, duty_d;

  logic [15:0] ctrl_word;
  logic [3:0]  bit_next;
  logic        div_last;

  assign ctrl_word = {2'b00, ch_cur_q, 11'b0};
  assign bit_next  = bit_q + 4'd1;
  assign div_last  = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    ch_cur_d    = ch_cur_q;
    ch_prev_d   = ch_prev_q;
    first_d     = first_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    saddr_d     = saddr_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    duty_d      = duty_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          ch_cur_d = channel;
          state_d  = S_SETUP;
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          div_d    = '0;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          saddr_d = ctrl_word[15];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
            // Only the trailing 12 of the 16 bits are kept; the leading 4 fall off the top.
            shreg_d = {shreg_q[10:0], ADC_SDAT};
            if (bit_q == 4'd15) begin
              state_d = S_HOLD;
              cs_n_d  = 1'b1;
              saddr_d = 1'b0;
            end else begin
              bit_d   = bit_next;
              half_d  = 1'b0;
              sclk_d  = 1'b0;
              saddr_d = ctrl_word[4'd15 - bit_next];
            end
          end
        end
      end
      default: begin // S_HOLD
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!first_q) begin
            sample_d    = shreg_q;
            sample_ch_d = ch_prev_q;
            duty_d      = shreg_q[11 -: OUT_WIDTH];
            valid_d     = 1'b1;
          end
          // The ADC answers one frame late, so the result belongs to the previous address.
          ch_prev_d = ch_cur_q;
          first_d   = 1'b0;
          if (enable) begin
            ch_cur_d = channel;
            state_d  = S_SETUP;
            cs_n_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            first_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      half_q      <= 1'b0;
      bit_q       <= '0;
      shreg_q     <= '0;
      ch_cur_q    <= '0;
      ch_prev_q   <= '0;
      first_q     <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      saddr_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      duty_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      ch_cur_q    <= ch_cur_d;
      ch_prev_q   <= ch_prev_d;
      first_q     <= first_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      saddr_q     <= saddr_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      duty_q      <= duty_d;
    end
  end

  assign sample    = sample_q;
  assign sample_ch = sample_ch_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign ADC_CS_N  = cs_n_q;
  assign ADC_SCLK  = sclk_q;
  assign ADC_SADDR = saddr_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: frame-timeline reference model plus ADC device model,
// expected results queued at frame end and popped by an independent valid monitor.
module tb_adc_spi_sampler;

  localparam int unsigned D     = 2;
  localparam int unsigned OW    = 7;
  localparam int unsigned FRAME = 34 * D;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          enable   = 1'b0;
  logic [2:0]    channel  = 3'd0;
  logic          ADC_SDAT = 1'b0;
  logic [11:0]   sample;
  logic [2:0]    sample_ch;
  logic [OW-1:0] duty;
  logic          valid, busy, ADC_CS_N, ADC_SADDR, ADC_SCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  adc_spi_sampler #(.CLK_DIV(D), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .channel   (channel),
    .sample    (sample),
    .sample_ch (sample_ch),
    .duty      (duty),
    .valid     (valid),
    .busy      (busy),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_SADDR (ADC_SADDR),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_SDAT  (ADC_SDAT)
  );

  always #5 clk = ~clk;

  // Inputs as seen by the DUT at each rising edge.
  logic       rs_s = 1'b1;
  logic       en_s = 1'b0;
  logic [2:0] ch_s = 3'd0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rs_s <= reset;
    en_s <= enable;
    ch_s <= channel;
  end

  typedef struct {
    logic [11:0] smp;
    logic [2:0]  ch;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] conv_val [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin levels {cs_n, sclk, saddr, busy} at cycle t of a frame addressing channel ch.
  function automatic logic [3:0] exp_pins(input int unsigned t, input logic [2:0] ch);
    logic [15:0] ctrl;
    int unsigned u, k;
    ctrl = {2'b00, ch, 11'b0};
    if (t < D) return 4'b0101;
    if (t < 33 * D) begin
      u = t - D;
      k = u / (2 * D);
      return {1'b0, ((u % (2 * D)) >= D), ctrl[15 - k], 1'b1};
    end
    return 4'b1101;
  endfunction

  // Reference model and ADC device model.
  bit          m_active  = 0;
  bit          m_first   = 1;
  bit          m_discard = 1;
  int unsigned m_t       = 0;
  logic [2:0]  m_ch      = 3'd0;
  logic [2:0]  m_tag     = 3'd0;
  logic [2:0]  m_last_ch = 3'd0;
  logic [15:0] m_word    = 16'd0;
  int          pin_err   = 0;
  string       pin_msg   = "";

  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] adc_word  = 16'd0;
  logic [15:0] adc_rx    = 16'd0;
  logic [2:0]  adc_addr  = 3'd0;
  int          adc_falls = 0;
  int          adc_rises = 0;

  always @(negedge clk) begin
    logic [3:0]  ep, ap;
    logic [26:0] rst_act;
    bit          start;
    exp_t        item;
    start = 0;
    if (rs_s) begin
      rst_act = {ADC_CS_N, ADC_SCLK, ADC_SADDR, busy, valid, sample, sample_ch, duty};
      chk("reset_state", 32'(rst_act), 32'h0600_0000);
      m_active = 0;
      m_first  = 1;
      m_t      = 0;
      sb.delete();
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) begin
          m_active = 0;
          m_first  = 0;
          if (en_s) start = 1;
          else m_first = 1;
        end
      end else if (en_s) begin
        start = 1;
      end
      if (start) begin
        m_active  = 1;
        m_t       = 0;
        m_discard = m_first;
        m_word    = conv_val[m_last_ch];
        m_tag     = m_last_ch;
        m_ch      = ch_s;
        m_last_ch = ch_s;
      end
      ep = m_active ? exp_pins(m_t, m_ch) : 4'b1100;
      ap = {ADC_CS_N, ADC_SCLK, ADC_SADDR, busy};
      if (ap !== ep) begin
        if (pin_err == 0)
          pin_msg = $sformatf("cycle %0d t=%0d got %b expected %b", cyc, m_t, ap, ep);
        pin_err++;
      end
      if (m_active && m_t == FRAME - 1) begin
        checks++;
        if (pin_err != 0) begin
          failures++;
          $display("FAIL frame_pins: %0d pin errors (cs_n,sclk,saddr,busy), first at %s", pin_err, pin_msg);
        end
        pin_err = 0;
        if (!m_discard) begin
          item.smp = m_word[11:0];
          item.ch  = m_tag;
          item.due = cyc + 1;
          sb.push_back(item);
        end
      end
    end

    // ADC: returns the word for the previously addressed channel, MSB first after each SCLK fall.
    if (prev_cs && !ADC_CS_N) begin
      adc_word  = conv_val[adc_addr];
      adc_falls = 0;
      adc_rises = 0;
      adc_rx    = 16'd0;
      ADC_SDAT  = adc_word[15];
    end else if (!ADC_CS_N) begin
      if (prev_sclk && !ADC_SCLK) begin
        adc_falls++;
        if (adc_falls <= 16) ADC_SDAT = adc_word[16 - adc_falls];
      end
      if (!prev_sclk && ADC_SCLK) begin
        adc_rises++;
        adc_rx = {adc_rx[14:0], ADC_SADDR};
        if (adc_rises == 5) adc_addr = adc_rx[2:0];
      end
    end
    prev_cs   = ADC_CS_N;
    prev_sclk = ADC_SCLK;
  end

  // Output monitor.
  always @(negedge clk) begin
    exp_t          e;
    logic [OW-1:0] exp_duty;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      failures++;
      $display("FAIL valid_missing: no valid by cycle %0d, required at cycle %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL valid_unexpected: valid=1 at cycle %0d, required 0 (sample=0x%0h)", cyc, sample);
      end else begin
        e = sb.pop_front();
        exp_duty = OW'(e.smp >> (12 - OW));
        chk("sample", 32'(sample), 32'(e.smp));
        chk("sample_ch", 32'(sample_ch), 32'(e.ch));
        chk("duty", 32'(duty), 32'(exp_duty));
        chk("valid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_conv_all(input logic [15:0] v);
    @(posedge clk);
    for (int i = 0; i < 8; i++) conv_val[i] = v;
    @(negedge clk);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not seen within bound, required within %0d cycles", name, 4 * FRAME);
  endtask

  task automatic wait_frame_start(output bit ok);
    logic p;
    ok = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      p = ADC_CS_N;
      @(negedge clk);
      if (p && !ADC_CS_N) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    int   n;
    logic ps;
    for (int i = 0; i < 8; i++) conv_val[i] = 16'h0ABC;
    // Enable already high while reset is held.
    enable  = 1'b1;
    channel = 3'd3;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4 * FRAME + 4);

    // Channel pipelining.
    set_conv_all(16'h0000);
    @(posedge clk);
    conv_val[1] = 16'h0111;
    conv_val[5] = 16'h0555;
    @(negedge clk);
    channel = 3'd1;
    wait_cyc(FRAME);
    channel = 3'd5;
    wait_cyc(FRAME);
    channel = 3'd2;
    wait_cyc(2 * FRAME);

    // Full scale, with nonzero leading bits that must be ignored.
    set_conv_all(16'hAFFF);
    wait_cyc(2 * FRAME + 3);
    set_conv_all(16'h5000);
    wait_cyc(2 * FRAME + 3);

    // Enable drops mid-frame.
    wait_cyc(FRAME / 2);
    enable = 1'b0;
    wait_cyc(2 * FRAME);

    // Single-cycle enable pulse.
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_cyc(2 * FRAME);

    // Reset at the 8th SCLK fall of a non-first frame.
    enable = 1'b1;
    channel = 3'd6;
    wait_frame_start(ok);
    if (!ok) timeout_fail("frame_start_1");
    wait_frame_start(ok);
    if (!ok) timeout_fail("frame_start_2");
    n  = 0;
    ps = ADC_SCLK;
    for (int i = 0; i < FRAME && n < 8; i++) begin
      @(negedge clk);
      if (ps && !ADC_SCLK) n++;
      ps = ADC_SCLK;
    end
    if (n < 8) timeout_fail("sclk_fall_8");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(3 * FRAME);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      @(posedge clk);
      for (int i = 0; i < 8; i++) conv_val[i] = 16'($urandom());
      @(negedge clk);
      enable  = ($urandom_range(0, 3) != 0);
      channel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      wait_cyc(int'($urandom_range(1, 150)));
    end

    enable = 1'b0;
    wait_cyc(3 * FRAME);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    checks++;
    if (pin_err != 0) begin
      failures++;
      $display("FAIL idle_pins: %0d pin errors (cs_n,sclk,saddr,busy), first at %s", pin_err, pin_msg);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
